// File: rtl/cpu_controller_if.sv
// Control bundle between the cpu_controller sequencer and the datapath.
// The master side is the sequencer. It receives the opcode, the zero flag and
// (optionally) resume, and it drives the phase and every control strobe.
// Optional feature macro: CTRL_RESUME_EN adds the resume request line.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
`ifdef CTRL_RESUME_EN
    logic       resume;
`endif
    logic [2:0] phase;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       wr;
    logic       data_e;
    logic       halt;

    modport master (
`ifdef CTRL_RESUME_EN
        input  resume,
`endif
        input  opcode, zero,
        output phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
    );

    modport slave (
`ifdef CTRL_RESUME_EN
        output resume,
`endif
        output opcode, zero,
        input  phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
    );
endinterface

// File: rtl/cpu_controller.sv
// Instruction sequencer for the 8-bit accumulator CPU.
// An 8-phase counter runs one instruction every 8 clocks: fetch happens in
// phases 0-3 and execute in phases 4-7. Every strobe is decoded combinationally
// from the phase, the opcode, the zero flag and the run mode.
// Optional feature macro: CTRL_RESUME_EN. When it is defined, a resume pulse
// while halted re-enters the run mode at phase 5. Phases 5-7 of the HLT
// instruction are then drained with no strobes. When it is undefined, only
// rst leaves the halted mode.
module cpu_controller (
    input  logic              clk,
    input  logic              rst,
    cpu_controller_if.master  ctrl
);

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        DRAIN
    } mode_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    mode_t      mode_q, mode_d;
    logic [2:0] phase_q, phase_d;

    logic       is_aluop;
    logic       sel_c, rd_c, ld_ir_c, inc_pc_c, ld_pc_c, ld_ac_c, wr_c, data_e_c, halt_c;

    // Phase counter and run mode register; reset restarts the fetch at phase 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 3'd0;
            mode_q  <= RUN;
        end else begin
            phase_q <= phase_d;
            mode_q  <= mode_d;
        end
    end

    // Next phase / mode: free-running wrap, freeze at 4 on HLT, optional resume
    always_comb begin
        phase_d = phase_q;
        mode_d  = mode_q;
        unique case (mode_q)
            RUN: begin
                if (phase_q == 3'd4 && ctrl.opcode == OP_HLT) begin
                    mode_d = HALTED;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            HALTED: begin
`ifdef CTRL_RESUME_EN
                if (ctrl.resume) begin
                    mode_d  = DRAIN;
                    phase_d = 3'd5;
                end
`endif
            end
            DRAIN: begin
                phase_d = phase_q + 3'd1;
                if (phase_q == 3'd7) begin
                    mode_d = RUN;
                end
            end
            default: begin
                mode_d  = RUN;
                phase_d = 3'd0;
            end
        endcase
    end

    // Strobe decode from phase, opcode and zero; halted/drain modes mute everything but halt
    always_comb begin
        sel_c    = 1'b0;
        rd_c     = 1'b0;
        ld_ir_c  = 1'b0;
        inc_pc_c = 1'b0;
        ld_pc_c  = 1'b0;
        ld_ac_c  = 1'b0;
        wr_c     = 1'b0;
        data_e_c = 1'b0;
        halt_c   = 1'b0;
        is_aluop = (ctrl.opcode == OP_ADD) || (ctrl.opcode == OP_AND) ||
                   (ctrl.opcode == OP_XOR) || (ctrl.opcode == OP_LDA);
        unique case (mode_q)
            RUN: begin
                unique case (phase_q)
                    3'd0: begin
                        sel_c = 1'b1;
                    end
                    3'd1: begin
                        sel_c = 1'b1;
                        rd_c  = 1'b1;
                    end
                    3'd2, 3'd3: begin
                        sel_c   = 1'b1;
                        rd_c    = 1'b1;
                        ld_ir_c = 1'b1;
                    end
                    3'd4: begin
                        inc_pc_c = 1'b1;
                        halt_c   = (ctrl.opcode == OP_HLT);
                    end
                    3'd5: begin
                        rd_c = is_aluop;
                    end
                    3'd6: begin
                        rd_c     = is_aluop;
                        inc_pc_c = (ctrl.opcode == OP_SKZ) && ctrl.zero;
                        ld_pc_c  = (ctrl.opcode == OP_JMP);
                        data_e_c = (ctrl.opcode == OP_STO);
                    end
                    3'd7: begin
                        rd_c     = is_aluop;
                        ld_ac_c  = is_aluop;
                        ld_pc_c  = (ctrl.opcode == OP_JMP);
                        wr_c     = (ctrl.opcode == OP_STO);
                        data_e_c = (ctrl.opcode == OP_STO);
                    end
                    default: begin
                        sel_c = 1'b0;
                    end
                endcase
            end
            HALTED: begin
                halt_c = 1'b1;
            end
            default: begin
                halt_c = 1'b0;
            end
        endcase
    end

    // Drive the bus; the memory write and the data-bus drive are also gated by rst
    always_comb begin
        ctrl.phase  = phase_q;
        ctrl.sel    = sel_c;
        ctrl.rd     = rd_c;
        ctrl.ld_ir  = ld_ir_c;
        ctrl.inc_pc = inc_pc_c;
        ctrl.ld_pc  = ld_pc_c;
        ctrl.ld_ac  = ld_ac_c;
        ctrl.wr     = wr_c & ~rst;
        ctrl.data_e = data_e_c & ~rst;
        ctrl.halt   = halt_c;
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller.
// A behavioural model tracks the instruction phase and the halted/draining
// condition. Each strobe is derived from rules written in terms of
// instruction behaviour, and the DUT is compared against the model once per
// cycle. Directed literal checks pin the model at key points.
// Optional feature macro: CTRL_RESUME_EN exercises the resume path.
module tb_cpu_controller;

    logic clk;
    logic rst;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    int modelPhase   = 0;
    bit modelHalted  = 1'b0;
    bit modelDrain   = 1'b0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: one instruction is eight cycles; HLT freezes the sequencer
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelPhase  = 0;
            modelHalted = 1'b0;
            modelDrain  = 1'b0;
        end else if (modelHalted) begin
`ifdef CTRL_RESUME_EN
            if (bus.resume) begin
                modelHalted = 1'b0;
                modelDrain  = 1'b1;
                modelPhase  = 5;
            end
`endif
        end else if (!modelDrain && modelPhase == 4 && bus.opcode == 3'd0) begin
            modelHalted = 1'b1;
        end else begin
            modelPhase = (modelPhase + 1) % 8;
            if (modelPhase == 0) modelDrain = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare of every DUT output against the model, mid low phase
    initial begin
        forever begin
            bit run, aluop, isSto, isJmp, isHlt;
            logic [12:0] expVec, gotVec;
            @(negedge clk);
            #2;
            run   = !modelHalted && !modelDrain;
            aluop = (bus.opcode >= 3'd2) && (bus.opcode <= 3'd5);
            isSto = (bus.opcode == 3'd6);
            isJmp = (bus.opcode == 3'd7);
            isHlt = (bus.opcode == 3'd0);
            expVec[12:10] = 3'(modelPhase);
            expVec[9] = run && modelPhase < 4;
            expVec[8] = run && ((modelPhase >= 1 && modelPhase <= 3) || (modelPhase >= 5 && aluop));
            expVec[7] = run && (modelPhase == 2 || modelPhase == 3);
            expVec[6] = run && (modelPhase == 4 || (modelPhase == 6 && bus.opcode == 3'd1 && bus.zero));
            expVec[5] = run && modelPhase >= 6 && isJmp;
            expVec[4] = run && modelPhase == 7 && aluop;
            expVec[3] = run && !rst && modelPhase == 7 && isSto;
            expVec[2] = run && !rst && modelPhase >= 6 && isSto;
            expVec[1] = modelHalted || (run && modelPhase == 4 && isHlt);
            expVec[0] = 1'b0;
            gotVec = {bus.phase, bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                      bus.ld_ac, bus.wr, bus.data_e, bus.halt, 1'b0};
            vectors++;
            if (gotVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL cycle {phase,sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}: got %b, expected %b at t=%0t",
                         gotVec[12:1], expVec[12:1], $time);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic z);
        bus.opcode = op;
        bus.zero   = z;
    endtask

    // Advance whole cycles until the DUT reaches phase p (bounded)
    task automatic waitPhase(input int p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #3;
            if (bus.phase == 3'(p)) found = 1'b1;
        end
        if (!found) begin
            miscompares++;
            vectors++;
            $display("[TB] FAIL waitPhase timeout: got phase %0d, expected %0d", bus.phase, p);
        end
    endtask

    initial begin
`ifdef CTRL_RESUME_EN
        bus.resume = 1'b0;
`endif
        applyStimulus(3'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #3;
        checkOutput("reset phase", bus.phase, 0);
        checkOutput("reset sel", bus.sel, 1);
        checkOutput("reset rd", bus.rd, 0);
        checkOutput("reset halt", bus.halt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        checkOutput("first edge phase", bus.phase, 1);

        // ADD instruction
        waitPhase(2);
        checkOutput("ADD ld_ir p2", bus.ld_ir, 1);
        waitPhase(4);
        checkOutput("ADD inc_pc p4", bus.inc_pc, 1);
        waitPhase(7);
        checkOutput("ADD ld_ac p7", bus.ld_ac, 1);
        checkOutput("ADD rd p7", bus.rd, 1);
        waitPhase(0);
        checkOutput("wrap sel p0", bus.sel, 1);

        // SKZ with zero set, then clear
        applyStimulus(3'd1, 1'b1);
        waitPhase(6);
        checkOutput("SKZ z=1 inc_pc p6", bus.inc_pc, 1);
        waitPhase(0);
        applyStimulus(3'd1, 1'b0);
        waitPhase(6);
        checkOutput("SKZ z=0 inc_pc p6", bus.inc_pc, 0);

        // JMP
        waitPhase(0);
        applyStimulus(3'd7, 1'b0);
        waitPhase(6);
        checkOutput("JMP ld_pc p6", bus.ld_pc, 1);
        checkOutput("JMP rd p6", bus.rd, 0);

        // STO full
        waitPhase(0);
        applyStimulus(3'd6, 1'b0);
        waitPhase(7);
        checkOutput("STO wr p7", bus.wr, 1);
        checkOutput("STO data_e p7", bus.data_e, 1);

        // STO interrupted by reset in phase 6
        waitPhase(6);
        checkOutput("STO data_e p6", bus.data_e, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst data_e", bus.data_e, 0);
        checkOutput("async rst wr", bus.wr, 0);
        checkOutput("async rst phase", bus.phase, 0);
        checkOutput("async rst sel", bus.sel, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        checkOutput("post rst phase", bus.phase, 1);

        // HLT
        waitPhase(0);
        applyStimulus(3'd0, 1'b0);
        waitPhase(4);
        checkOutput("HLT halt p4", bus.halt, 1);
        checkOutput("HLT inc_pc p4", bus.inc_pc, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 8) applyStimulus(3'd2, 1'b1);
        end
        #3;
        checkOutput("halted phase", bus.phase, 4);
        checkOutput("halted halt", bus.halt, 1);
        checkOutput("halted inc_pc", bus.inc_pc, 0);

`ifdef CTRL_RESUME_EN
        @(negedge clk);
        bus.resume = 1'b1;
        @(negedge clk);
        bus.resume = 1'b0;
        #3;
        checkOutput("resume phase", bus.phase, 5);
        checkOutput("resume halt", bus.halt, 0);
        checkOutput("drain rd", bus.rd, 0);
        waitPhase(7);
        checkOutput("drain ld_ac p7", bus.ld_ac, 0);
        waitPhase(0);
        checkOutput("after drain sel", bus.sel, 1);
        waitPhase(2);
        bus.resume = 1'b1;
        @(negedge clk);
        bus.resume = 1'b0;
        #3;
        checkOutput("run resume ignored", bus.phase, 3);
`else
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        checkOutput("rst exits halt", bus.phase, 1);
        checkOutput("rst exits halt flag", bus.halt, 0);
`endif
        waitPhase(7);
        checkOutput("ADD after halt ld_ac", bus.ld_ac, 1);
        repeat (3) @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
